// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its storage array.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int LEN_W      = 3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, one access (read or write) per cycle.
// Latency: read data is registered, valid the cycle after the read is issued.
// Backpressure: none; read data holds its value while no read is issued (including writes).
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    // Registered read port; the output register alone is reset so the response bus starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en && !we) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: single-word and up to 8-beat burst loads/stores with programmable wait states.
// Latency: first beat WAIT_CYCLES+1 cycles after accept, then one beat per cycle.
// Backpressure: req_ready is low from accept until the edge ending the last beat; no response-side stall.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [LEN_W-1:0]  rsp_beat,
    output logic              rsp_last,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [3:0]         wait_q, wait_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   base_q, base_d;
    logic               we_q, we_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               ready_q, ready_d;

    logic               mem_en;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [DATA_W-1:0]  mem_rdata;

    // Address bits above the storage index are ignored by design.
    generate
        if (ADDR_W > IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    // State and control registers; reset returns to IDLE with every response output cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            base_q  <= '0;
            we_q    <= OP_READ;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            base_q  <= base_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ready_q <= ready_d;
        end
    end

    // Next-state, beat sequencing and RAM port control. XFER opens with one issue cycle
    // (first read launched, no beat shown) so read data is registered for every beat.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        len_d   = len_q;
        base_d  = base_q;
        we_d    = we_q;
        valid_d = valid_q;
        last_d  = last_q;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        mem_idx = base_q + IDX_W'(beat_q);

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    we_d   = req_we;
                    base_d = req_addr[IDX_W-1:0];
                    len_d  = req_len;
                    if (WAIT_CYCLES != 0) begin
                        state_d = WAIT;
                        wait_d  = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = XFER;
                    end
                end
            end

            WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = XFER;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end

            XFER: begin
                if (!valid_q) begin
                    // Issue cycle: beat 0 becomes visible at the next edge.
                    valid_d = 1'b1;
                    beat_d  = '0;
                    last_d  = (len_q == '0);
                    if (we_q == OP_READ) begin
                        mem_en  = 1'b1;
                        mem_idx = base_q;
                    end
                end else begin
                    // Edge ending the current beat: commit the write beat, or fetch the next read word.
                    if (we_q == OP_WRITE) begin
                        mem_en  = 1'b1;
                        mem_we  = 1'b1;
                        mem_idx = base_q + IDX_W'(beat_q);
                    end
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                        last_d = ((beat_q + 3'd1) == len_q);
                        if (we_q == OP_READ) begin
                            mem_en  = 1'b1;
                            mem_idx = base_q + IDX_W'(beat_q + 3'd1);
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                beat_d  = '0;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (mem_en),
        .we     (mem_we),
        .idx    (mem_idx),
        .wdata  (req_wdata),
        .rdata  (mem_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = mem_rdata;
    assign rsp_beat  = beat_q;
    assign rsp_last  = last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (WAIT_CYCLES = 2)
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [2:0]  req_len = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [2:0]  rsp_beat;
    logic        rsp_last;
    logic        busy;

    // Zero-wait DUT
    logic        z_valid = 1'b0;
    logic        z_ready;
    logic        z_we = 1'b0;
    logic [15:0] z_addr = '0;
    logic [2:0]  z_len = '0;
    logic [15:0] z_wdata = '0;
    logic        z_rsp_valid;
    logic [15:0] z_rsp_rdata;
    logic [2:0]  z_rsp_beat;
    logic        z_rsp_last;
    logic        z_busy;

    mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_beat(rsp_beat),
        .rsp_last(rsp_last), .busy(busy)
    );

    mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
        .req_addr(z_addr), .req_len(z_len), .req_wdata(z_wdata),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_beat(z_rsp_beat),
        .rsp_last(z_rsp_last), .busy(z_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [15:0] data;
        logic [2:0]  beat;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0][15:0] seq(input logic [15:0] b);
        logic [7:0][15:0] r;
        for (int k = 0; k < 8; k++) r[k] = b + 16'(k);
        return r;
    endfunction

    // Scoreboard monitor: every presented beat is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_beat", 32'(rsp_beat), 32'(mon_e.beat));
                chk("rsp_last", 32'(rsp_last), 32'(mon_e.last));
                chk("beat_cycle", 32'(cyc), 32'(mon_e.cyc));
                if (!mon_e.we) chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.data));
            end
        end
    end

    // Issue one request; d holds write data or expected read data per beat.
    // abort >= 0 asserts reset asynchronously in the middle of that beat.
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [2:0] len,
                          input logic [7:0][15:0] d, input int abort, output int t0);
        int guard = 0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            t0 = -1;
            return;
        end
        @(posedge clk);
        #1;
        t0 = cyc;
        // Fields are don't-care after accept: scramble them.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 16'h5A5A;
        req_len   = 3'd5;
        for (int k = 0; k <= int'(len); k++) begin
            if (abort >= 0 && k > abort) break;
            e.we   = we;
            e.data = d[k];
            e.beat = 3'(k);
            e.last = (k == int'(len));
            e.cyc  = t0 + W + 1 + k;
            sbq.push_back(e);
        end
        for (int k = 0; k <= int'(len); k++) begin
            if (k == 0) repeat (W + 1) @(posedge clk);
            else @(posedge clk);
            #1;
            req_wdata = d[k];
            if (k == abort) begin
                #6;
                rst_n = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t, ta, tb2;
        logic [7:0][15:0] d;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_req_ready_after_edge", 32'(req_ready), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);

        // Single write then read
        d = '0; d[0] = 16'hBEEF;
        do_req(1'b1, 16'h0010, 3'd0, d, -1, t);
        do_req(1'b0, 16'h0010, 3'd0, d, -1, t);

        // 8-word burst write then read
        do_req(1'b1, 16'h0020, 3'd7, seq(16'h1000), -1, t);
        do_req(1'b0, 16'h0020, 3'd7, seq(16'h1000), -1, t);

        // Wrap-around write at the top of storage
        d = '0; d[0] = 16'h000A; d[1] = 16'h000B; d[2] = 16'h000C;
        do_req(1'b1, 16'h00FE, 3'd2, d, -1, t);
        do_req(1'b0, 16'h00FE, 3'd2, d, -1, t);
        d = '0; d[0] = 16'h000C;
        do_req(1'b0, 16'h0000, 3'd0, d, -1, t);
        // Upper address bits ignored: 0x01FF aliases 0x00FF
        d = '0; d[0] = 16'h000B;
        do_req(1'b0, 16'h01FF, 3'd0, d, -1, t);

        // Busy rejection: second request held valid during a burst
        ta = 0; tb2 = 0;
        fork
            do_req(1'b0, 16'h0020, 3'd7, seq(16'h1000), -1, ta);
            begin
                repeat (3) @(negedge clk);
                chk("busy_during_burst", 32'(busy), 32'd1);
                chk("ready_during_burst", 32'(req_ready), 32'd0);
                d = '0; d[0] = 16'hBEEF;
                do_req(1'b0, 16'h0010, 3'd0, d, -1, tb2);
            end
        join
        chk("second_accept_cycle", 32'(tb2), 32'(ta + W + 10));

        // Zero wait states: beat 0 one edge after accept
        @(negedge clk);
        chk("z_ready", 32'(z_ready), 32'd1);
        z_valid = 1'b1; z_we = 1'b1; z_addr = 16'h0033; z_len = 3'd0; z_wdata = 16'h1234;
        @(posedge clk); #1;
        z_valid = 1'b0;
        chk("z_busy_after_accept", 32'(z_busy), 32'd1);
        chk("z_valid_at_accept", 32'(z_rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("z_wr_beat_valid", 32'(z_rsp_valid), 32'd1);
        chk("z_wr_beat_last", 32'(z_rsp_last), 32'd1);
        chk("z_wr_beat_idx", 32'(z_rsp_beat), 32'd0);
        @(posedge clk); #1;
        chk("z_valid_after_last", 32'(z_rsp_valid), 32'd0);
        chk("z_ready_after_last", 32'(z_ready), 32'd1);
        @(negedge clk);
        z_valid = 1'b1; z_we = 1'b0; z_addr = 16'h0033; z_wdata = 16'h0000;
        @(posedge clk); #1;
        z_valid = 1'b0;
        @(posedge clk); #1;
        chk("z_rd_valid", 32'(z_rsp_valid), 32'd1);
        chk("z_rd_data", 32'(z_rsp_rdata), 32'h1234);

        // Reset in the middle of a write burst
        do_req(1'b1, 16'h0040, 3'd7, seq(16'h2000), -1, t);
        do_req(1'b1, 16'h0040, 3'd7, seq(16'h3000), 3, t);
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rsp_beat", 32'(rsp_beat), 32'd0);
        chk("mid_rst_rsp_last", 32'(rsp_last), 32'd0);
        chk("mid_rst_sb_drained", 32'(sbq.size()), 32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ready_after_release", 32'(req_ready), 32'd1);
        d = seq(16'h2000);
        d[0] = 16'h3000; d[1] = 16'h3001; d[2] = 16'h3002;
        do_req(1'b0, 16'h0040, 3'd7, d, -1, t);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty_at_end", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
